// File: rtl/my_logic_pkg.sv
// my_logic_pkg: operation codes and shared constants for the my_logic_pipe datapath.
package my_logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT     = 3'd0,
    OP_AND     = 3'd1,
    OP_OR      = 3'd2,
    OP_XOR     = 3'd3,
    OP_MUX     = 3'd4,
    OP_DMUX    = 3'd5,
    OP_ACC_XOR = 3'd6,
    OP_ACC_CLR = 3'd7
  } op_e;

  function automatic logic is_acc_op(input op_e op);
    return (op == OP_ACC_XOR) || (op == OP_ACC_CLR);
  endfunction

endpackage

// File: rtl/my_logic_stage.sv
// my_logic_stage: one valid/ready register slice with a generic payload width.
// Accepts a beat whenever it is empty or its current beat leaves in the same cycle.
module my_logic_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/my_logic_pipe.sv
// my_logic_pipe: two-stage WIDTH-bit logic unit (NOT/AND/OR/XOR/MUX/DMUX) with valid/ready handshakes.
// Define MY_LOGIC_PIPE_ACC_EN to add the XOR accumulator behind ops ACC_XOR/ACC_CLR.
module my_logic_pipe
  import my_logic_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_op,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [SEL_W-1:0]          in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHANNELS*WIDTH-1:0] out_dmux,
  output logic                      out_err
);

  localparam int S1_W = OP_W + 2 * WIDTH + SEL_W;
  localparam int S2_W = WIDTH + CHANNELS * WIDTH + 1;

  logic                      s1_valid;
  logic [S1_W-1:0]           s1_data;
  logic                      s2_in_ready;
  logic [S2_W-1:0]           s2_in_data;
  logic [S2_W-1:0]           s2_data;

  op_e                       s1_op;
  logic [WIDTH-1:0]          s1_a;
  logic [WIDTH-1:0]          s1_b;
  logic [SEL_W-1:0]          s1_sel;

  logic [WIDTH-1:0]          res_data;
  logic [CHANNELS*WIDTH-1:0] res_dmux;
  logic                      res_err;

  my_logic_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_a, in_b, in_sel}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign s1_op  = op_e'(s1_data[S1_W-1 -: OP_W]);
  assign s1_a   = s1_data[SEL_W+WIDTH +: WIDTH];
  assign s1_b   = s1_data[SEL_W +: WIDTH];
  assign s1_sel = s1_data[SEL_W-1:0];

`ifdef MY_LOGIC_PIPE_ACC_EN
  logic             s1_fire;
  logic [WIDTH-1:0] acc_q, acc_d;

  // The accumulator advances only when its op leaves S1, so a stalled op never applies twice.
  assign s1_fire = s1_valid && s2_in_ready;

  always_comb begin
    acc_d = acc_q;
    if (s1_fire) begin
      if (s1_op == OP_ACC_XOR) begin
        acc_d = acc_q ^ s1_a;
      end else if (s1_op == OP_ACC_CLR) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_comb begin
    res_data = '0;
    res_dmux = '0;
    res_err  = 1'b0;
    case (s1_op)
      OP_NOT: res_data = ~s1_a;
      OP_AND: res_data = s1_a & s1_b;
      OP_OR:  res_data = s1_a | s1_b;
      OP_XOR: res_data = s1_a ^ s1_b;
      OP_MUX: res_data = (s1_sel == '0) ? s1_a : s1_b;
      OP_DMUX: begin
        // Selects past the last channel only exist when CHANNELS is not a power of two.
        res_err = (int'(s1_sel) >= CHANNELS);
        for (int c = 0; c < CHANNELS; c++) begin
          if (int'(s1_sel) == c) begin
            res_dmux[c*WIDTH +: WIDTH] = s1_a;
          end
        end
      end
      default: begin
`ifdef MY_LOGIC_PIPE_ACC_EN
        res_data = (s1_op == OP_ACC_XOR) ? (acc_q ^ s1_a) : acc_q;
`else
        res_err = is_acc_op(s1_op);
`endif
      end
    endcase
  end

  assign s2_in_data = {res_data, res_dmux, res_err};

  my_logic_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_data = s2_data[S2_W-1 -: WIDTH];
  assign out_dmux = s2_data[1 +: CHANNELS*WIDTH];
  assign out_err  = s2_data[0];

endmodule

// File: tb/tb_my_logic_pipe.sv
// tb_my_logic_pipe: scoreboard bench for my_logic_pipe (default 16x4 instance plus a 8x3 instance).
// Expected results follow MY_LOGIC_PIPE_ACC_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_my_logic_pipe;
  import my_logic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [63:0] out_dmux;
  logic        out_err;

  logic        in_valid3;
  logic        in_ready3;
  logic [2:0]  in_op3;
  logic [7:0]  in_a3;
  logic [7:0]  in_b3;
  logic [1:0]  in_sel3;
  logic        out_valid3;
  logic        out_ready3;
  logic [7:0]  out_data3;
  logic [23:0] out_dmux3;
  logic        out_err3;

  my_logic_pipe #(.WIDTH(16), .CHANNELS(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dmux(out_dmux), .out_err(out_err)
  );

  my_logic_pipe #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op3),
    .in_a(in_a3), .in_b(in_b3), .in_sel(in_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .out_dmux(out_dmux3), .out_err(out_err3)
  );

  typedef struct {
    logic [15:0] data;
    logic [63:0] dmux;
    logic        err;
    int          cyc;
    logic        pop;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [15:0] acc_m = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model; the accumulator advances in acceptance order, which matches result order.
  function automatic beat_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] sel);
    beat_t r;
    r.data = '0; r.dmux = '0; r.err = 1'b0; r.cyc = 0; r.pop = 1'b0;
    case (op)
      3'd0: r.data = ~a;
      3'd1: r.data = a & b;
      3'd2: r.data = a | b;
      3'd3: r.data = a ^ b;
      3'd4: r.data = (sel != 2'd0) ? b : a;
      3'd5: r.dmux[int'(sel)*16 +: 16] = a;
      3'd6: begin
`ifdef MY_LOGIC_PIPE_ACC_EN
        acc_m  = acc_m ^ a;
        r.data = acc_m;
`else
        r.err = 1'b1;
`endif
      end
      default: begin
`ifdef MY_LOGIC_PIPE_ACC_EN
        r.data = acc_m;
        acc_m  = '0;
`else
        r.err = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboard capture: push expectations on input handshakes, record every visible output beat.
  always @(negedge clk) begin : monitor
    beat_t e;
    beat_t o;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e = model(in_op, in_a, in_b, in_sel);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid) begin
        o.data = out_data; o.dmux = out_dmux; o.err = out_err;
        o.cyc = cyc; o.pop = out_ready;
        obs_q.push_back(o);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] sel, output int waited);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_sel = sel;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 40) begin
        n_checks++;
        $display("[TB] FAIL send_timeout in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b required 0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 16'h0 || out_dmux !== 64'h0 || out_err !== 1'b0)
      $display("[TB] FAIL reset_payload got=%h/%h/%b required 0/0/0", out_data, out_dmux, out_err);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w;
    int ready_stalls = 0;
    out_ready = 1'b1;
    for (int op = 0; op < 5; op++) begin
      send(3'(op), 16'hF0F0, 16'h0FF0, 2'd1, w);
      ready_stalls += w;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (ready_stalls != 0) $display("[TB] FAIL b2b_in_ready stalls=%0d required 0", ready_stalls); else n_pass++;
    n_checks++;
    if (obs_q.size() != 5) $display("[TB] FAIL b2b_count got=%0d required 5", obs_q.size()); else n_pass++;
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL b2b_extra data=%h required no beat", obs_q[i].data);
      else if (obs_q[i].data !== exp_q[0].data || obs_q[i].dmux !== exp_q[0].dmux ||
               obs_q[i].err !== exp_q[0].err || obs_q[i].cyc - exp_q[0].cyc != 2)
        $display("[TB] FAIL b2b_beat data=%h dmux=%h err=%b lat=%0d required data=%h dmux=%h err=%b lat=2",
                 obs_q[i].data, obs_q[i].dmux, obs_q[i].err, obs_q[i].cyc - exp_q[0].cyc,
                 exp_q[0].data, exp_q[0].dmux, exp_q[0].err);
      else n_pass++;
      if (exp_q.size() != 0 && obs_q[i].pop) exp_q.delete(0);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL b2b_missing left=%0d required 0", exp_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_dmux();
    int w;
    out_ready = 1'b1;
    send(3'd5, 16'hBEEF, 16'h1111, 2'd2, w);
    send(3'd5, 16'h1234, 16'h2222, 2'd0, w);
    send(3'd5, 16'h00FF, 16'h3333, 2'd3, w);
    send(3'd4, 16'hAAAA, 16'h5555, 2'd2, w);
    repeat (6) @(posedge clk);
    #1;
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL dmux_extra data=%h required no beat", obs_q[i].data);
      else if (obs_q[i].data !== exp_q[0].data || obs_q[i].dmux !== exp_q[0].dmux || obs_q[i].err !== exp_q[0].err)
        $display("[TB] FAIL dmux_beat data=%h dmux=%h err=%b required data=%h dmux=%h err=%b",
                 obs_q[i].data, obs_q[i].dmux, obs_q[i].err, exp_q[0].data, exp_q[0].dmux, exp_q[0].err);
      else n_pass++;
      if (exp_q.size() != 0 && obs_q[i].pop) exp_q.delete(0);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL dmux_missing left=%0d required 0", exp_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int w0, w1, w2, w3;
    int ready_hi = 0;
    out_ready = 1'b0;
    send(3'd1, 16'h1234, 16'hFF00, 2'd0, w0);
    send(3'd2, 16'h1200, 16'h0034, 2'd0, w1);
    in_valid = 1'b1; in_op = 3'd3; in_a = 16'hAAAA; in_b = 16'hFFFF; in_sel = 2'd0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) ready_hi++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd3, 16'hAAAA, 16'hFFFF, 2'd0, w2);
    send(3'd0, 16'h8001, 16'h0000, 2'd0, w3);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (w0 != 0 || w1 != 0) $display("[TB] FAIL bp_first_two waits=%0d/%0d required 0/0", w0, w1); else n_pass++;
    n_checks++;
    if (ready_hi != 0) $display("[TB] FAIL bp_in_ready_drop high_cycles=%0d required 0", ready_hi); else n_pass++;
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL bp_extra data=%h required no beat", obs_q[i].data);
      else if (obs_q[i].data !== exp_q[0].data || obs_q[i].dmux !== exp_q[0].dmux || obs_q[i].err !== exp_q[0].err)
        $display("[TB] FAIL bp_beat data=%h err=%b required data=%h err=%b",
                 obs_q[i].data, obs_q[i].err, exp_q[0].data, exp_q[0].err);
      else n_pass++;
      if (exp_q.size() != 0 && obs_q[i].pop) exp_q.delete(0);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL bp_missing left=%0d required 0", exp_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_acc();
    int w;
    out_ready = 1'b1;
    send(3'd6, 16'h00FF, 16'h0000, 2'd0, w);
    send(3'd6, 16'h0F0F, 16'h0000, 2'd0, w);
    send(3'd7, 16'h0000, 16'h0000, 2'd0, w);
    send(3'd6, 16'h0001, 16'h0000, 2'd0, w);
    repeat (6) @(posedge clk);
    #1;
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL acc_extra data=%h required no beat", obs_q[i].data);
      else if (obs_q[i].data !== exp_q[0].data || obs_q[i].dmux !== exp_q[0].dmux || obs_q[i].err !== exp_q[0].err)
        $display("[TB] FAIL acc_beat data=%h err=%b required data=%h err=%b",
                 obs_q[i].data, obs_q[i].err, exp_q[0].data, exp_q[0].err);
      else n_pass++;
      if (exp_q.size() != 0 && obs_q[i].pop) exp_q.delete(0);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL acc_missing left=%0d required 0", exp_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b0;
    send(3'd6, 16'h1234, 16'h0000, 2'd0, w);
    send(3'd1, 16'hFFFF, 16'h5A5A, 2'd0, w);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid got=%b required 0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 16'h0 || out_dmux !== 64'h0 || out_err !== 1'b0)
      $display("[TB] FAIL midrst_payload got=%h/%h/%b required 0/0/0", out_data, out_dmux, out_err);
    else n_pass++;
    obs_q.delete();
    exp_q.delete();
    acc_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0 || out_valid !== 1'b0)
      $display("[TB] FAIL midrst_spurious beats=%0d out_valid=%b required 0/0", obs_q.size(), out_valid);
    else n_pass++;
    send(3'd7, 16'h0000, 16'h0000, 2'd0, w);
    send(3'd6, 16'h0001, 16'h0000, 2'd0, w);
    repeat (6) @(posedge clk);
    #1;
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL midrst_extra data=%h required no beat", obs_q[i].data);
      else if (obs_q[i].data !== exp_q[0].data || obs_q[i].dmux !== exp_q[0].dmux || obs_q[i].err !== exp_q[0].err)
        $display("[TB] FAIL midrst_beat data=%h err=%b required data=%h err=%b",
                 obs_q[i].data, obs_q[i].err, exp_q[0].data, exp_q[0].err);
      else n_pass++;
      if (exp_q.size() != 0 && obs_q[i].pop) exp_q.delete(0);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL midrst_missing left=%0d required 0", exp_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int w;
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL rand_extra data=%h required no beat", obs_q[i].data);
      else if (obs_q[i].data !== exp_q[0].data || obs_q[i].dmux !== exp_q[0].dmux || obs_q[i].err !== exp_q[0].err)
        $display("[TB] FAIL rand_beat data=%h dmux=%h err=%b required data=%h dmux=%h err=%b",
                 obs_q[i].data, obs_q[i].dmux, obs_q[i].err, exp_q[0].data, exp_q[0].dmux, exp_q[0].err);
      else n_pass++;
      if (exp_q.size() != 0 && obs_q[i].pop) exp_q.delete(0);
    end
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL rand_missing left=%0d required 0", exp_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_dmux_3ch();
    logic [1:0]  sels[2];
    logic [23:0] exp_dmux[2];
    logic        exp_err[2];
    int          t;
    sels[0] = 2'd3; exp_dmux[0] = 24'h000000; exp_err[0] = 1'b1;
    sels[1] = 2'd2; exp_dmux[1] = 24'hA50000; exp_err[1] = 1'b0;
    out_ready3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid3 = 1'b1; in_op3 = 3'd5; in_a3 = 8'hA5; in_b3 = 8'h3C; in_sel3 = sels[k];
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      t = 0;
      forever begin
        @(negedge clk);
        if (out_valid3 || t > 10) break;
        t++;
      end
      n_checks++;
      if (out_valid3 !== 1'b1 || out_dmux3 !== exp_dmux[k] || out_err3 !== exp_err[k] || out_data3 !== 8'h00)
        $display("[TB] FAIL ch3_dmux sel=%0d valid=%b dmux=%h err=%b data=%h required 1/%h/%b/00",
                 sels[k], out_valid3, out_dmux3, out_err3, out_data3, exp_dmux[k], exp_err[k]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_op3 = '0; in_a3 = '0; in_b3 = '0; in_sel3 = '0; out_ready3 = 1'b1;
    test_reset();
    test_back_to_back();
    test_dmux();
    test_backpressure();
    test_acc();
    test_reset_mid();
    test_dmux_3ch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/my_logic_pipe.md
# my_logic_pipe

Parametrised, pipelined successor to the single-bit gate set: one WIDTH-bit logic unit performing NOT/AND/OR/XOR/MUX/DMUX selected per transaction, with a CHANNELS-way demultiplexer. Operands enter and results leave through valid/ready handshakes with two register stages, so the unit sits directly between streaming producers and consumers in the datapath. An optional XOR accumulator adds stateful reduction.

## Interface
Parameters:
- WIDTH, 16, operand/result width (>=1)
- CHANNELS, 4, DMUX output count (>=2)

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit accepts beat this cycle
- in_op  input  3  operation code (op_e)
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_sel  input  $clog2(CHANNELS)  mux/dmux select
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  scalar result
- out_dmux  output  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- out_err  output  1  illegal op or select for this beat

## Operation
- Op codes: 0 NOT (~a), 1 AND, 2 OR, 3 XOR, 4 MUX (sel==0 ? a : b), 5 DMUX (out_data=0; channel sel = a, others 0), 6 ACC_XOR, 7 ACC_CLR.
- Non-DMUX ops drive out_dmux all-zero.
- DMUX with sel >= CHANNELS (non-power-of-two CHANNELS): out_dmux all-zero, out_err=1.
- MUX uses whole sel: any nonzero sel selects b.
- Stage 1 (S1) captures op/a/b/sel on in_valid && in_ready. Stage 2 (S2) holds computed result.
- Each stage: accept when empty or downstream pops same cycle. in_ready = !s1_valid || s2_accept; s2_accept = !out_valid || out_ready.
- Full throughput: one beat per cycle when out_ready held high.
- Output payload stable while out_valid && !out_ready.
- Results emerge strictly in input order; no beat dropped or duplicated.

## Timing
- Latency: beat accepted at edge N appears with out_valid at edge N+2 (no backpressure).
- Reset (asynchronous assert, synchronous-safe deassert): s1_valid=0, out_valid=0, out_data=0, out_dmux=0, out_err=0, accumulator=0; in_ready=1 from first cycle after reset.
- Reset mid-operation discards both in-flight beats; no output after release until new input.
- Backpressure: with out_ready low, S2 holds, S1 fills, then in_ready drops in the cycle after S1 fills; at most 2 beats buffered.
- Simultaneous pop at S2 and push at S1 in same cycle: both occur, no bubble.
- Accumulator updates at the edge the op moves S1->S2 (not at input acceptance).

## Configuration
- MY_LOGIC_PIPE_ACC_EN defined: WIDTH-bit accumulator present. ACC_XOR: acc <= acc ^ a, out_data = new acc. ACC_CLR: acc <= 0, out_data = old acc. out_err=0.
- Undefined: no accumulator register; ops 6/7 produce out_data=0, out_dmux=0, out_err=1; pipeline behaviour otherwise identical.

## Structure
- Package my_logic_pkg: op_e enum (3-bit, codes above), OP_W=3 constant.
- Sub-module my_logic_stage: generic valid/ready register slice parametrised on payload width, instantiated for S1 and S2; compute logic and accumulator live in my_logic_pipe between them.

## Test plan
- Reset then ops 0–4 back-to-back, a=16'hF0F0, b=16'h0FF0, sel=1, out_ready=1 -> results FFFF... wait-free order: 0F0F, 00F0, FFF0, FF00, 0FF0 at cycles 2–6, in_ready always 1.
- DMUX a=16'hBEEF sel=2 -> out_dmux channel 2 = BEEF, channels 0,1,3 = 0, out_data=0, out_err=0.
- Backpressure: 4 beats offered, out_ready low 5 cycles -> in_ready drops after 2 accepted, out payload stable, then all 4 delivered in order once out_ready high.
- ACC_EN: ACC_XOR a=0x00FF, ACC_XOR a=0x0F0F, ACC_CLR -> out_data 00FF, 0FF0, 0FF0; following ACC_XOR a=1 -> 0001. Without macro: same stream -> out_data 0, out_err=1 each.
- CHANNELS=3, DMUX sel=3 -> out_dmux all zero, out_err=1.
- Assert rst_n low with 2 beats in flight -> out_valid falls immediately, outputs zero; after release no spurious beat, accumulator reads 0.
